// File: rtl/dff_delay_line_pkg.sv
// Shared types and helpers for the configurable delay line.
package dff_delay_line_pkg;

  // Per-edge operating mode of the whole chain.
  typedef enum logic [1:0] {
    MODE_SHIFT    = 2'b00,
    MODE_LOAD_ALL = 2'b01,
    MODE_ROTATE   = 2'b10,
    MODE_HOLD     = 2'b11
  } mode_e;

  // Bits needed to hold a fill count from 0 up to and including depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_stage.sv
// One stage of the delay line: a data word plus its valid flag.
// The next value is chosen by the parent, so the stage only knows
// reset, clear and enable.
module dff_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d_next,
  input  logic             v_next,
  output logic [WIDTH-1:0] data,
  output logic             vld
);

  // Async clear on reset low, then sync clear, then enabled load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= '0;
      vld  <= 1'b0;
    end else if (clr) begin
      data <= '0;
      vld  <= 1'b0;
    end else if (en) begin
      data <= d_next;
      vld  <= v_next;
    end
  end

endmodule

// File: rtl/dff_delay_line.sv
// WIDTH x DEPTH register chain with per-stage valid, shift / load-all /
// rotate / hold modes, enable, synchronous clear and a fill counter.
//
// Flow control: valid_in only qualifies D; there is no ready. Every
// enabled SHIFT edge moves the chain whether or not entries are valid,
// so a bubble (valid_in=0) travels down the chain like any other entry.
module dff_delay_line
  import dff_delay_line_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       clr,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           D,
  input  logic                       valid_in,
  output logic [WIDTH-1:0]           Q,
  output logic [WIDTH-1:0]           Qbar,
  output logic                       valid_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int CW = count_width(DEPTH);

  mode_e            mode_s;
  logic             stage_en;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic             vld_q  [DEPTH];
  logic [WIDTH-1:0] d_next [DEPTH];
  logic             v_next [DEPTH];
  logic [CW-1:0]    count_q;

  assign mode_s = mode_e'(mode);

  // HOLD behaves exactly like en=0, so fold it into the stage enable.
  assign stage_en = en && (mode_s != MODE_HOLD);

  // Next value of every stage: stage 0 takes D (shift) or the tail
  // (rotate); the others take their upstream neighbour; load-all
  // broadcasts D. With DEPTH=1 rotate feeds the stage back to itself.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      d_next[i] = D;
      v_next[i] = valid_in;
    end
    if (mode_s != MODE_LOAD_ALL) begin
      if (mode_s == MODE_ROTATE) begin
        d_next[0] = data_q[DEPTH-1];
        v_next[0] = vld_q[DEPTH-1];
      end
      for (int i = 1; i < DEPTH; i++) begin
        d_next[i] = data_q[i-1];
        v_next[i] = vld_q[i-1];
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    dff_stage #(.WIDTH(WIDTH)) u_stage (
      .clk    (clk),
      .reset  (reset),
      .en     (stage_en),
      .clr    (clr),
      .d_next (d_next[g]),
      .v_next (v_next[g]),
      .data   (data_q[g]),
      .vld    (vld_q[g])
    );
  end

  // Fill counter tracks entries in minus entries out; rotate keeps all
  // entries in the chain so the count is left alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      case (mode_s)
        MODE_SHIFT:    count_q <= count_q + CW'(valid_in) - CW'(vld_q[DEPTH-1]);
        MODE_LOAD_ALL: count_q <= valid_in ? CW'(DEPTH) : '0;
        default:       count_q <= count_q;
      endcase
    end
  end

  assign Q         = data_q[DEPTH-1];
  assign Qbar      = ~Q;
  assign valid_out = vld_q[DEPTH-1];
  assign count     = count_q;
  assign full      = (count_q == CW'(DEPTH));

endmodule

// File: tb/tb_dff_delay_line.sv
// Bench for dff_delay_line: WIDTH=8/DEPTH=4 main instance plus a
// WIDTH=1/DEPTH=1 instance, table vectors, hand sequences and a
// random run scored against a reference model through a queue.
module tb_dff_delay_line;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // main instance (8 x 4)
  logic       en, clr, vin;
  logic [1:0] mode;
  logic [7:0] d, q, qbar;
  logic       vout, full;
  logic [2:0] cnt;

  // small instance (1 x 1)
  logic       en1, clr1, vin1;
  logic [1:0] mode1;
  logic [0:0] d1, q1, qbar1;
  logic       vout1, full1;
  logic [0:0] cnt1;

  dff_delay_line #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .mode(mode), .D(d),
    .valid_in(vin), .Q(q), .Qbar(qbar), .valid_out(vout), .count(cnt), .full(full)
  );

  dff_delay_line #(.WIDTH(1), .DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .en(en1), .clr(clr1), .mode(mode1), .D(d1),
    .valid_in(vin1), .Q(q1), .Qbar(qbar1), .valid_out(vout1), .count(cnt1), .full(full1)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];   // {valid_out, Q, count} for the 8x4 instance
  logic [2:0]  exp1_q[$];  // {valid_out, Q, count} for the 1x1 instance

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_data [4];
  logic       m_vld  [4];
  logic       m1_q, m1_v;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_data[i] = 8'h00;
      m_vld[i]  = 1'b0;
    end
    m1_q = 1'b0;
    m1_v = 1'b0;
  endtask

  task automatic model_step();
    logic [7:0] td;
    logic       tv;
    if (clr) begin
      for (int i = 0; i < 4; i++) begin
        m_data[i] = 8'h00;
        m_vld[i]  = 1'b0;
      end
    end else if (en) begin
      case (mode)
        2'b00: begin
          for (int i = 3; i > 0; i--) begin
            m_data[i] = m_data[i-1];
            m_vld[i]  = m_vld[i-1];
          end
          m_data[0] = d;
          m_vld[0]  = vin;
        end
        2'b01: begin
          for (int i = 0; i < 4; i++) begin
            m_data[i] = d;
            m_vld[i]  = vin;
          end
        end
        2'b10: begin
          td = m_data[3];
          tv = m_vld[3];
          for (int i = 3; i > 0; i--) begin
            m_data[i] = m_data[i-1];
            m_vld[i]  = m_vld[i-1];
          end
          m_data[0] = td;
          m_vld[0]  = tv;
        end
        default: ;
      endcase
    end
    if (clr1) begin
      m1_q = 1'b0;
      m1_v = 1'b0;
    end else if (en1 && (mode1 == 2'b00 || mode1 == 2'b01)) begin
      m1_q = d1[0];
      m1_v = vin1;
    end
  endtask

  // count is expected to equal the number of valid stages
  function automatic logic [2:0] model_count();
    logic [2:0] c = 3'd0;
    for (int i = 0; i < 4; i++) c += {2'b00, m_vld[i]};
    return c;
  endfunction

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic c, input logic [1:0] m,
                       input logic [7:0] dd, input logic v);
    en = e; clr = c; mode = m; d = dd; vin = v;
  endtask

  task automatic drive1(input logic e, input logic c, input logic [1:0] m,
                        input logic dd, input logic v);
    en1 = e; clr1 = c; mode1 = m; d1 = dd; vin1 = v;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_q"},     {24'h0, q},    32'h00);
    check({tag, "_qbar"},  {24'h0, qbar}, 32'hFF);
    check({tag, "_vout"},  {31'h0, vout}, 32'h0);
    check({tag, "_count"}, {29'h0, cnt},  32'h0);
    check({tag, "_full"},  {31'h0, full}, 32'h0);
    check({tag, "_q1"},    {31'h0, q1},   32'h0);
    check({tag, "_qbar1"}, {31'h0, qbar1}, 32'h1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       en;
    logic       clr;
    logic [1:0] mode;
    logic [7:0] d;
    logic       vin;
    logic [7:0] eq;
    logic       ev;
    logic [2:0] ec;
  } vec_t;

  vec_t vecs [32];

  initial begin
    logic [11:0] e12;
    logic [2:0]  e3;

    // SHIFT stream 11..55 then drain with bubbles
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 8'h11, 1'b1, 8'h00, 1'b0, 3'd1};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 8'h22, 1'b1, 8'h00, 1'b0, 3'd2};
    vecs[2]  = '{1'b1, 1'b0, 2'd0, 8'h33, 1'b1, 8'h00, 1'b0, 3'd3};
    vecs[3]  = '{1'b1, 1'b0, 2'd0, 8'h44, 1'b1, 8'h11, 1'b1, 3'd4};
    vecs[4]  = '{1'b1, 1'b0, 2'd0, 8'h55, 1'b1, 8'h22, 1'b1, 3'd4};
    vecs[5]  = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'h33, 1'b1, 3'd3};
    vecs[6]  = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'h44, 1'b1, 3'd2};
    vecs[7]  = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'h55, 1'b1, 3'd1};
    vecs[8]  = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0};
    // same stream with a stall on cycle 3 and 33 sent as a bubble
    vecs[9]  = '{1'b1, 1'b0, 2'd0, 8'h11, 1'b1, 8'h00, 1'b0, 3'd1};
    vecs[10] = '{1'b1, 1'b0, 2'd0, 8'h22, 1'b1, 8'h00, 1'b0, 3'd2};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 8'h33, 1'b1, 8'h00, 1'b0, 3'd2};
    vecs[12] = '{1'b1, 1'b0, 2'd0, 8'h33, 1'b0, 8'h00, 1'b0, 3'd2};
    vecs[13] = '{1'b1, 1'b0, 2'd0, 8'h44, 1'b1, 8'h11, 1'b1, 3'd3};
    vecs[14] = '{1'b1, 1'b0, 2'd0, 8'h55, 1'b1, 8'h22, 1'b1, 3'd3};
    vecs[15] = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'h33, 1'b0, 3'd2};
    vecs[16] = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'h44, 1'b1, 3'd2};
    vecs[17] = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'h55, 1'b1, 3'd1};
    vecs[18] = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0};
    // LOAD_ALL A5, shift 01..03, rotate four times
    vecs[19] = '{1'b1, 1'b0, 2'd1, 8'hA5, 1'b1, 8'hA5, 1'b1, 3'd4};
    vecs[20] = '{1'b1, 1'b0, 2'd0, 8'h01, 1'b1, 8'hA5, 1'b1, 3'd4};
    vecs[21] = '{1'b1, 1'b0, 2'd0, 8'h02, 1'b1, 8'hA5, 1'b1, 3'd4};
    vecs[22] = '{1'b1, 1'b0, 2'd0, 8'h03, 1'b1, 8'hA5, 1'b1, 3'd4};
    vecs[23] = '{1'b1, 1'b0, 2'd2, 8'hEE, 1'b1, 8'h01, 1'b1, 3'd4};
    vecs[24] = '{1'b1, 1'b0, 2'd2, 8'hEE, 1'b1, 8'h02, 1'b1, 3'd4};
    vecs[25] = '{1'b1, 1'b0, 2'd2, 8'hEE, 1'b1, 8'h03, 1'b1, 3'd4};
    vecs[26] = '{1'b1, 1'b0, 2'd2, 8'hEE, 1'b1, 8'hA5, 1'b1, 3'd4};
    // clr beats en=0 and LOAD_ALL; then en=0, HOLD, invalid load, shift
    vecs[27] = '{1'b0, 1'b1, 2'd1, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0};
    vecs[28] = '{1'b0, 1'b0, 2'd0, 8'h77, 1'b1, 8'h00, 1'b0, 3'd0};
    vecs[29] = '{1'b1, 1'b0, 2'd3, 8'h77, 1'b1, 8'h00, 1'b0, 3'd0};
    vecs[30] = '{1'b1, 1'b0, 2'd1, 8'h3C, 1'b0, 8'h3C, 1'b0, 3'd0};
    vecs[31] = '{1'b1, 1'b0, 2'd0, 8'hC3, 1'b1, 8'h3C, 1'b0, 3'd1};

    // ---------- reset held low with random inputs ----------
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'($urandom_range(0, 1)), 1'b0, 2'($urandom_range(0, 3)),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      drive1(1'b1, 1'b0, 2'd0, 1'($urandom_range(0, 1)), 1'b1);
      tick();
      check_reset_state("reset_hold");
    end
    reset = 1'b1;
    drive1(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

    // ---------- table vectors ----------
    for (int i = 0; i < 32; i++) begin
      drive(vecs[i].en, vecs[i].clr, vecs[i].mode, vecs[i].d, vecs[i].vin);
      model_step();
      tick();
      check($sformatf("vec%0d_q", i),     {24'h0, q},    {24'h0, vecs[i].eq});
      check($sformatf("vec%0d_qbar", i),  {24'h0, qbar}, {24'h0, ~vecs[i].eq});
      check($sformatf("vec%0d_vout", i),  {31'h0, vout}, {31'h0, vecs[i].ev});
      check($sformatf("vec%0d_count", i), {29'h0, cnt},  {29'h0, vecs[i].ec});
      check($sformatf("vec%0d_full", i),  {31'h0, full}, {31'h0, (vecs[i].ec == 3'd4)});
    end

    // ---------- asynchronous reset mid-stream ----------
    drive(1'b1, 1'b0, 2'd1, 8'hA5, 1'b1);
    model_step();
    tick();
    check("pre_reset_q", {24'h0, q}, 32'hA5);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check_reset_state("async_reset");
    drive(1'b1, 1'b0, 2'd1, 8'h99, 1'b1);
    tick();
    check_reset_state("async_reset_edge");
    reset = 1'b1;

    // release is live on the very next edge; D appears after DEPTH edges
    drive(1'b1, 1'b0, 2'd0, 8'h5A, 1'b1);
    model_step();
    tick();
    check("post_release_count", {29'h0, cnt}, 32'd1);
    check("post_release_q", {24'h0, q}, 32'h00);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
      model_step();
      tick();
    end
    check("latency_q", {24'h0, q}, 32'h5A);
    check("latency_vout", {31'h0, vout}, 32'h1);

    // ---------- DEPTH=1 / WIDTH=1 corner cases ----------
    drive(1'b0, 1'b0, 2'd3, 8'h00, 1'b0);
    drive1(1'b1, 1'b0, 2'd0, 1'b1, 1'b1);
    model_step();
    tick();
    check("d1_shift_q", {31'h0, q1}, 32'h1);
    check("d1_shift_qbar", {31'h0, qbar1}, 32'h0);
    check("d1_shift_count", {31'h0, cnt1}, 32'h1);
    check("d1_shift_full", {31'h0, full1}, 32'h1);
    drive1(1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
    model_step();
    tick();
    check("d1_rotate_q", {31'h0, q1}, 32'h1);
    check("d1_rotate_vout", {31'h0, vout1}, 32'h1);
    check("d1_rotate_count", {31'h0, cnt1}, 32'h1);
    drive1(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    model_step();
    tick();
    check("d1_bubble_q", {31'h0, q1}, 32'h0);
    check("d1_bubble_count", {31'h0, cnt1}, 32'h0);
    check("d1_bubble_full", {31'h0, full1}, 32'h0);

    // ---------- random regression through the scoreboard ----------
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
            2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)));
      drive1(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      model_step();
      exp_q.push_back({m_vld[3], m_data[3], model_count()});
      exp1_q.push_back({m1_v, m1_q, m1_v});
      tick();
      e12 = exp_q.pop_front();
      e3  = exp1_q.pop_front();
      check($sformatf("rnd%0d_main", c), {20'h0, vout, q, cnt}, {20'h0, e12});
      check($sformatf("rnd%0d_qbar", c), {24'h0, qbar}, {24'h0, ~e12[10:3]});
      check($sformatf("rnd%0d_full", c), {31'h0, full}, {31'h0, (e12[2:0] == 3'd4)});
      check($sformatf("rnd%0d_small", c), {29'h0, vout1, q1, cnt1}, {29'h0, e3});
      check($sformatf("rnd%0d_full1", c), {31'h0, full1}, {31'h0, e3[0]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
